// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: combinational lookup from the fetch PC,
// execute-stage updates with 2-bit style saturating counters, round-robin victims.
module btb_assoc #(
    parameter int SETS     = 32,
    parameter int WAYS     = 2,
    parameter int CNT_BITS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_req,
    output logic        busy,
    input  logic [31:0] lookup_pc,
    output logic        hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);
    // state  | meaning
    // S_INIT | clear sweep: one set per cycle, lookups forced to miss, updates dropped
    // S_RUN  | normal lookup and update

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [CNT_BITS-1:0] CNT_WEAK = CNT_BITS'(1) << (CNT_BITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               busy_q;

    logic [WAYS-1:0]    valid_q  [SETS];
    logic [TAG_W-1:0]   tag_q    [SETS][WAYS];
    logic [31:0]        target_q [SETS][WAYS];
    logic [CNT_BITS-1:0] cnt_q   [SETS][WAYS];
    logic [WAY_W-1:0]   vptr_q   [SETS];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= (state_d == S_INIT);
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (flush_req) begin
            state_d = S_INIT;
            ptr_d   = '0;
        end else if (state_q == S_INIT) begin
            if (ptr_q == IDX_W'(SETS - 1)) begin
                state_d = S_RUN;
                ptr_d   = '0;
            end else begin
                ptr_d = ptr_q + 1'b1;
            end
        end
    end

    assign busy = busy_q;

    // ---------------- lookup ----------------
    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    logic             l_hit;
    logic             l_msb;
    logic [31:0]      l_target;

    assign l_idx = lookup_pc[IDX_W+1:2];
    assign l_tag = lookup_pc[31:IDX_W+2];

    always_comb begin
        l_hit    = 1'b0;
        l_msb    = 1'b0;
        l_target = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[l_idx][w] && (tag_q[l_idx][w] == l_tag)) begin
                l_hit    = 1'b1;
                l_msb    = cnt_q[l_idx][w][CNT_BITS-1];
                l_target = target_q[l_idx][w];
            end
        end
    end

    assign hit         = (state_q == S_RUN) && l_hit;
    assign pred_taken  = (state_q == S_RUN) && l_hit && l_msb;
    assign pred_target = ((state_q == S_RUN) && l_hit) ? l_target : 32'd0;

    // ---------------- update ----------------
    logic [IDX_W-1:0]    u_idx;
    logic [TAG_W-1:0]    u_tag;
    logic                u_hit;
    logic [WAY_W-1:0]    u_hit_way;
    logic                u_has_inv;
    logic [WAY_W-1:0]    u_inv_way;
    logic                upd_en;
    logic                wr_en;
    logic [WAY_W-1:0]    wr_way;
    logic [31:0]         wr_target;
    logic [CNT_BITS-1:0] wr_cnt;
    logic [CNT_BITS-1:0] cur_cnt;
    logic                vptr_we;
    logic [WAY_W-1:0]    vptr_nx;

    assign u_idx  = upd_pc[IDX_W+1:2];
    assign u_tag  = upd_pc[31:IDX_W+2];
    assign upd_en = (state_q == S_RUN) && upd_valid && !flush_req && !rst;

    always_comb begin
        u_hit     = 1'b0;
        u_hit_way = '0;
        u_has_inv = 1'b0;
        u_inv_way = '0;
        // descending scan so the lowest-index invalid way wins
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[u_idx][w]) begin
                u_has_inv = 1'b1;
                u_inv_way = WAY_W'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) begin
                u_hit     = 1'b1;
                u_hit_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        wr_en     = 1'b0;
        wr_way    = '0;
        wr_target = '0;
        wr_cnt    = '0;
        vptr_we   = 1'b0;
        vptr_nx   = '0;
        cur_cnt   = cnt_q[u_idx][u_hit_way];
        if (upd_en) begin
            if (u_hit) begin
                wr_en  = 1'b1;
                wr_way = u_hit_way;
                if (upd_taken) begin
                    wr_target = upd_target;
                    wr_cnt    = (cur_cnt == CNT_MAX) ? cur_cnt : cur_cnt + 1'b1;
                end else begin
                    wr_target = target_q[u_idx][u_hit_way];
                    wr_cnt    = (cur_cnt == '0) ? cur_cnt : cur_cnt - 1'b1;
                end
            end else if (upd_taken) begin
                wr_en     = 1'b1;
                wr_target = upd_target;
                wr_cnt    = CNT_WEAK;
                if (u_has_inv) begin
                    wr_way = u_inv_way;
                end else begin
                    wr_way  = vptr_q[u_idx];
                    vptr_we = 1'b1;
                    // with one way the pointer is a single always-zero bit
                    vptr_nx = (WAYS > 1) ? vptr_q[u_idx] + 1'b1 : '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            valid_q[ptr_q] <= '0;
            vptr_q[ptr_q]  <= '0;
        end else if (wr_en) begin
            valid_q[u_idx][wr_way] <= 1'b1;
            if (vptr_we) begin
                vptr_q[u_idx] <= vptr_nx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[u_idx][wr_way]    <= u_tag;
            target_q[u_idx][wr_way] <= wr_target;
            cnt_q[u_idx][wr_way]    <= wr_cnt;
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc (32 sets, 2 ways, 2-bit counters) with
// hand-computed expected predictions.
module tb_btb_assoc;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush_req;
    logic        busy;
    logic [31:0] lookup_pc;
    logic        hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;

    int n_total = 0;
    int n_bad   = 0;

    btb_assoc #(.SETS(32), .WAYS(2), .CNT_BITS(2)) dut (
        .clk(clk), .rst(rst), .flush_req(flush_req), .busy(busy),
        .lookup_pc(lookup_pc), .hit(hit), .pred_taken(pred_taken),
        .pred_target(pred_target), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_taken(upd_taken), .upd_target(upd_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
        tick();
        upd_valid  = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic eh,
                        input logic ep, input logic [31:0] et);
        lookup_pc = pc;
        #1;
        chk({tag, ".hit"}, {31'd0, hit}, {31'd0, eh});
        chk({tag, ".pt"},  {31'd0, pred_taken}, {31'd0, ep});
        chk({tag, ".tgt"}, pred_target, et);
    endtask

    // counts edges until busy falls; optionally keeps an update asserted meanwhile
    task automatic busy_len(input string tag, input logic drive_upd);
        int n;
        n = 0;
        while (busy && n < 100) begin
            if (drive_upd) begin
                upd_valid  = 1'b1;
                upd_pc     = 32'h88;
                upd_taken  = 1'b1;
                upd_target = 32'h900;
            end
            tick();
            n++;
        end
        upd_valid = 1'b0;
        chk(tag, n, 32);
    endtask

    initial begin
        rst = 1'b1; flush_req = 1'b0; lookup_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        tick();
        chk("rst.busy", {31'd0, busy}, 32'd1);
        look("rst.look", 32'h80, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        busy_len("rst.busy_len", 1'b0);
        look("init.80", 32'h80, 1'b0, 1'b0, 32'h0);

        // allocation and no-allocate on not-taken miss
        upd(32'h80, 1'b1, 32'h200);
        look("alloc.80", 32'h80, 1'b1, 1'b1, 32'h200);
        look("alloc.84", 32'h84, 1'b0, 1'b0, 32'h0);
        upd(32'h300, 1'b0, 32'h555);
        look("nt.300", 32'h300, 1'b0, 1'b0, 32'h0);

        // counter walk: 10 -> 01 -> 00 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10 -> 01
        upd(32'h80, 1'b0, 32'h0);   look("c01a", 32'h80, 1'b1, 1'b0, 32'h200);
        upd(32'h80, 1'b0, 32'h0);   look("c00a", 32'h80, 1'b1, 1'b0, 32'h200);
        upd(32'h80, 1'b0, 32'h0);   look("c00b", 32'h80, 1'b1, 1'b0, 32'h200);
        upd(32'h80, 1'b1, 32'h240); look("c01b", 32'h80, 1'b1, 1'b0, 32'h240);
        upd(32'h80, 1'b1, 32'h240); look("c10a", 32'h80, 1'b1, 1'b1, 32'h240);
        upd(32'h80, 1'b1, 32'h240); look("c11a", 32'h80, 1'b1, 1'b1, 32'h240);
        upd(32'h80, 1'b1, 32'h240); look("c11b", 32'h80, 1'b1, 1'b1, 32'h240);
        upd(32'h80, 1'b0, 32'h0);   look("c10b", 32'h80, 1'b1, 1'b1, 32'h240);
        upd(32'h80, 1'b0, 32'h0);   look("c01c", 32'h80, 1'b1, 1'b0, 32'h240);

        // replacement in set 0: 0x80 in way0, then way1, then round-robin
        upd(32'h80,   1'b1, 32'h100);
        upd(32'h1080, 1'b1, 32'h200);
        upd(32'h2080, 1'b1, 32'h300);
        look("rr.80",   32'h80,   1'b0, 1'b0, 32'h0);
        look("rr.1080", 32'h1080, 1'b1, 1'b1, 32'h200);
        look("rr.2080", 32'h2080, 1'b1, 1'b1, 32'h300);
        upd(32'h3080, 1'b1, 32'h400);
        look("rr2.1080", 32'h1080, 1'b0, 1'b0, 32'h0);
        look("rr2.2080", 32'h2080, 1'b1, 1'b1, 32'h300);
        look("rr2.3080", 32'h3080, 1'b1, 1'b1, 32'h400);
        upd(32'h1080, 1'b1, 32'h500);
        look("rr3.2080", 32'h2080, 1'b0, 1'b0, 32'h0);
        look("rr3.3080", 32'h3080, 1'b1, 1'b1, 32'h400);
        look("rr3.1080", 32'h1080, 1'b1, 1'b1, 32'h500);

        // same-cycle lookup and update: pre-update contents seen
        lookup_pc  = 32'h84;
        upd_valid  = 1'b1; upd_pc = 32'h84; upd_taken = 1'b1; upd_target = 32'h5a0;
        #1;
        chk("byp.pre", {31'd0, hit}, 32'd0);
        tick();
        upd_valid = 1'b0;
        look("byp.post", 32'h84, 1'b1, 1'b1, 32'h5a0);

        // flush with a simultaneous update; updates while busy are dropped
        upd(32'h80, 1'b1, 32'h600);
        look("fl.pre", 32'h80, 1'b1, 1'b1, 32'h600);
        flush_req = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h400; upd_taken = 1'b1; upd_target = 32'h700;
        tick();
        flush_req = 1'b0;
        upd_valid = 1'b0;
        chk("fl.busy", {31'd0, busy}, 32'd1);
        look("fl.during", 32'h84, 1'b0, 1'b0, 32'h0);
        busy_len("fl.busy_len", 1'b1);
        look("fl.80",  32'h80,  1'b0, 1'b0, 32'h0);
        look("fl.400", 32'h400, 1'b0, 1'b0, 32'h0);
        look("fl.88",  32'h88,  1'b0, 1'b0, 32'h0);
        look("fl.84",  32'h84,  1'b0, 1'b0, 32'h0);

        // reset in the 10th busy cycle restarts the sweep
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid.busy", {31'd0, busy}, 32'd1);
        busy_len("mid.busy_len", 1'b0);
        upd(32'h80, 1'b1, 32'h880);
        look("mid.80", 32'h80, 1'b1, 1'b1, 32'h880);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
